ahbl_to_apb: RTL

//  AHB-Lite slave to APB master bridge, one outstanding transfer. Sits directly upstream
//  of the APB splitter: it converts CPU-side AHB-Lite transfers into APB SETUP/ACCESS

---
 rtl/ahbl_to_apb.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ahbl_to_apb.sv
// ---------------------------------------------------------------------------
// ahbl_to_apb
//   AHB-Lite slave to APB master bridge with a single outstanding transfer.
//   An accepted AHB address phase becomes an APB SETUP/ACCESS sequence. The
//   AHB data phase is stalled until the APB completer answers. Read data and
//   the two-cycle AHB ERROR response are then returned to the master.
//
// Ports
//   clk, rst            clock (rising edge) and async active-high reset
//   ahbls_hready        global AHB hready, qualifies the address phase
//   ahbls_hready_resp   this slave's hready (low = data phase stalled)
//   ahbls_hresp         1 = ERROR response
//   ahbls_haddr/hwrite/htrans/hsize   address phase controls (hsize ignored)
//   ahbls_hwdata        write data, valid during the data phase
//   ahbls_hrdata        registered read data
//   apbm_paddr/psel/penable/pwrite/pwdata   registered APB requester outputs
//   apbm_pready/prdata/pslverr              APB completer response
// ---------------------------------------------------------------------------
module ahbl_to_apb #(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
) (
  input  logic               clk,
  input  logic               rst,
  // AHB-Lite slave side
  input  logic               ahbls_hready,
  output logic               ahbls_hready_resp,
  output logic               ahbls_hresp,
  input  logic [W_HADDR-1:0] ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,
  // APB requester side
  output logic [W_PADDR-1:0] apbm_paddr,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [W_DATA-1:0]  apbm_pwdata,
  input  logic               apbm_pready,
  input  logic [W_DATA-1:0]  apbm_prdata,
  input  logic               apbm_pslverr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_ERR0,
    S_ERR1
  } state_t;

  state_t              state_q;
  logic                hready_resp_q;
  logic                hresp_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [W_PADDR-1:0]  paddr_q;
  logic [W_DATA-1:0]   pwdata_q;
  logic [W_DATA-1:0]   hrdata_q;
  logic                accept;

  // Transfer size is irrelevant (all accesses are full-word) and the upper
  // address bits are outside the APB window; fold them into a sink.
  logic unused_ok;
  assign unused_ok = ^{ahbls_hsize, ahbls_haddr[W_HADDR-1:W_PADDR]};

  // A new address is only taken in the two states that present hready_resp=1,
  // so at most one APB transfer is ever in flight.
  assign accept = ahbls_hready & ahbls_htrans[1] &
                  ((state_q == S_IDLE) | (state_q == S_ERR1));

  // NOTE: every register below, the wide datapath ones included, is reset.
  // The outputs are defined from the instant rst asserts, and the bus-facing
  // data registers read as zero until the first transfer loads them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hready_resp_q <= 1'b1;
      hresp_q       <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      hrdata_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout. Each branch reads the
      // pre-edge state, so the order of the statements does not matter.
      case (state_q)
        S_IDLE, S_ERR1: begin
          hresp_q <= 1'b0;
          if (accept) begin
            paddr_q       <= ahbls_haddr[W_PADDR-1:0];
            pwrite_q      <= ahbls_hwrite;
            hready_resp_q <= 1'b0;
            if (ahbls_hwrite) begin
              // Write data only arrives in the next (data phase) cycle.
              state_q <= S_WDATA;
            end else begin
              state_q <= S_SETUP;
              psel_q  <= 1'b1;
            end
          end else begin
            state_q       <= S_IDLE;
            hready_resp_q <= 1'b1;
          end
        end

        S_WDATA: begin
          pwdata_q <= ahbls_hwdata;
          psel_q   <= 1'b1;
          state_q  <= S_SETUP;
        end

        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (apbm_pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (apbm_pslverr) begin
              // Hold hready_resp low for the first error cycle.
              hresp_q <= 1'b1;
              state_q <= S_ERR0;
            end else begin
              if (!pwrite_q) begin
                hrdata_q <= apbm_prdata;
              end
              hready_resp_q <= 1'b1;
              state_q       <= S_IDLE;
            end
          end
        end

        S_ERR0: begin
          hready_resp_q <= 1'b1;
          state_q       <= S_ERR1;
        end

        default: begin
          state_q       <= S_IDLE;
          hready_resp_q <= 1'b1;
          hresp_q       <= 1'b0;
          psel_q        <= 1'b0;
          penable_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ahbls_hready_resp = hready_resp_q;
  assign ahbls_hresp       = hresp_q;
  assign ahbls_hrdata      = hrdata_q;
  assign apbm_paddr        = paddr_q;
  assign apbm_psel         = psel_q;
  assign apbm_penable      = penable_q;
  assign apbm_pwrite       = pwrite_q;
  assign apbm_pwdata       = pwdata_q;

endmodule
